pll_rate_switch: RTL and testbench



---
 rtl/pll_rate_switch.sv | 195 +++++++++++++++++++
 tb/tb_pll_rate_switch.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rate_switch.sv
// pll_rate_switch: retunes the system PLL between the native and the ~1% underclocked
// 60 Hz K-fraction through the pll_cfg reconfiguration management port.
//
// Build option: define PLL_LOCK_WAIT_EN to wait for the PLL to drop and regain lock
// after the start write (with per-state timeouts and a lock_err pulse). Without it the
// sequence completes on the start-write accept, `locked` is ignored and lock_err is 0.
//
// Ports:
//   clk              management clock (50 MHz)
//   reset            synchronous, active-high
//   sel              asynchronous rate select, 0 = native, 1 = underclock
//   mgmt_waitrequest Avalon-MM waitrequest from pll_cfg
//   mgmt_write       write strobe, held with address/data until accepted
//   mgmt_address     register address
//   mgmt_writedata   register data
//   locked           asynchronous PLL lock
//   busy             high while a retune sequence is in flight
//   applied_sel      last rate committed
//   done             one-cycle pulse at sequence completion
//   lock_err         one-cycle pulse when the lock wait times out
module pll_rate_switch #(
  parameter logic [31:0] FRAC_NATIVE   = 32'd3639383488,
  parameter logic [31:0] FRAC_UNDER    = 32'd3262113561,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  input  logic        locked,
  output logic        busy,
  output logic        applied_sel,
  output logic        done,
  output logic        lock_err
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [3:0] {
    StIdle, StWrMode, StGap0, StWrFrac, StGap1, StWrStart, StWaitUnlock, StWaitLock, StDone
  } state_e;

  state_e     state;
  logic       sel_meta, sel_sync;
  logic [7:0] stab_cnt;
  logic       sel_acc_q, sel_acc;
  logic       tgt;
  logic       accept;

  // Select synchronizer and debounce. The counter restarts on the edge where a new value
  // enters sel_sync, so a level is accepted once it has been seen STABLE_CYCLES times more.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_meta  <= 1'b0;
      sel_sync  <= 1'b0;
      stab_cnt  <= '0;
      sel_acc_q <= 1'b0;
    end else begin
      sel_meta  <= sel;
      sel_sync  <= sel_meta;
      sel_acc_q <= sel_acc;
      if (sel_meta != sel_sync) begin
        stab_cnt <= '0;
      end else if (stab_cnt != StableMax) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

  assign sel_acc = (stab_cnt == StableMax) ? sel_sync : sel_acc_q;
  assign accept  = mgmt_write & ~mgmt_waitrequest;

`ifdef PLL_LOCK_WAIT_EN
  localparam logic [15:0] TimeoutMax = 16'(LOCK_TIMEOUT);

  logic        lock_meta, lock_sync;
  logic [15:0] unlock_cnt, lock_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{locked, 16'(LOCK_TIMEOUT)};
  assign lock_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      applied_sel    <= 1'b0;
      done           <= 1'b0;
      tgt            <= 1'b0;
`ifdef PLL_LOCK_WAIT_EN
      lock_err       <= 1'b0;
      unlock_cnt     <= '0;
      lock_cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PLL_LOCK_WAIT_EN
      lock_err <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (sel_acc != applied_sel) begin
            tgt            <= sel_acc;
            busy           <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            state          <= StWrMode;
          end
        end
        StWrMode: begin
          if (accept) begin
            mgmt_write <= 1'b0;
            state      <= StGap0;
          end
        end
        StGap0: begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= 6'd7;
          mgmt_writedata <= tgt ? FRAC_UNDER : FRAC_NATIVE;
          state          <= StWrFrac;
        end
        StWrFrac: begin
          if (accept) begin
            mgmt_write <= 1'b0;
            state      <= StGap1;
          end
        end
        StGap1: begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= 6'd2;
          mgmt_writedata <= 32'd0;
          state          <= StWrStart;
        end
        StWrStart: begin
          if (accept) begin
            mgmt_write <= 1'b0;
`ifdef PLL_LOCK_WAIT_EN
            unlock_cnt <= '0;
            state      <= StWaitUnlock;
`else
            state       <= StDone;
            done        <= 1'b1;
            busy        <= 1'b0;
            applied_sel <= tgt;
`endif
          end
        end
`ifdef PLL_LOCK_WAIT_EN
        // An unlock shorter than the synchronizer can see is not an error.
        StWaitUnlock: begin
          if (!lock_sync || unlock_cnt == TimeoutMax) begin
            lock_cnt <= '0;
            state    <= StWaitLock;
          end else begin
            unlock_cnt <= unlock_cnt + 16'd1;
          end
        end
        StWaitLock: begin
          if (lock_sync || lock_cnt == TimeoutMax) begin
            lock_err    <= ~lock_sync;
            state       <= StDone;
            done        <= 1'b1;
            busy        <= 1'b0;
            applied_sel <= tgt;
          end else begin
            lock_cnt <= lock_cnt + 16'd1;
          end
        end
`endif
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rate_switch.sv
// Self-checking bench for pll_rate_switch: reset state, a table of select scenarios,
// hand-written latency / stall / reset / lock-timeout sequences, then random select and
// waitrequest activity checked by a protocol-level reference model.
module tb_pll_rate_switch;

  localparam int          Stable     = 4;
  localparam int          LT         = 40;
  localparam logic [31:0] FracNative = 32'd3639383488;
  localparam logic [31:0] FracUnder  = 32'd3262113561;
`ifdef PLL_LOCK_WAIT_EN
  localparam int Extra = 2 * (LT + 10);
`else
  localparam int Extra = 0;
`endif

  logic        clk;
  logic        reset;
  logic        sel;
  logic        mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        locked;
  logic        busy;
  logic        applied_sel;
  logic        done;
  logic        lock_err;

  pll_rate_switch #(
    .FRAC_NATIVE  (FracNative),
    .FRAC_UNDER   (FracUnder),
    .STABLE_CYCLES(Stable),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sel             (sel),
    .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write      (mgmt_write),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .locked          (locked),
    .busy            (busy),
    .applied_sel     (applied_sel),
    .done            (done),
    .lock_err        (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic sel;
    int   hold;
    int   stall;
    logic exp_applied;
    int   exp_done;
    int   exp_writes;
  } vec_t;

  int checks, errors;
  int cyc;
  // waitrequest driver: 0 none, 1 stall N per write, 2 random, 3 stall address 7 forever
  int wmode, stall_n, stall_addr, stall_cnt;

  // reference model / monitor state
  wr_t        wq[$];
  logic       model_applied;
  logic       prev_valid, prev_write, prev_wait, prev_acc;
  logic [5:0] prev_addr;
  logic [31:0] prev_data;
  int done_cnt, wr_total, acc7_cnt, lock_err_cnt, start_cyc, done_cyc;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    wq.delete();
    prev_valid    = 1'b0;
    model_applied = 1'b0;
  endtask

  // Protocol-level model: writes hold until accepted, are followed by an idle cycle, only
  // occur while busy, and every completed sequence is exactly mode/frac/start for a target
  // that differs from the previously applied rate.
  task automatic monitor();
    logic acc;
    wr_t  e[3];
    if (reset) begin
      mon_clear();
      return;
    end
    acc = mgmt_write && !mgmt_waitrequest;
    if (prev_valid) begin
      if (prev_write && prev_wait) begin
        chk_eq("hold_write", mgmt_write, 1);
        chk_eq("hold_addr", mgmt_address, prev_addr);
        chk_eq("hold_data", mgmt_writedata, prev_data);
      end
      if (prev_acc) chk_eq("gap_after_write", mgmt_write, 0);
    end
    if (mgmt_write) chk_eq("write_while_busy", busy, 1);
    if (acc) begin
      wq.push_back('{a: mgmt_address, d: mgmt_writedata});
      wr_total++;
      if (mgmt_address == 6'd7) acc7_cnt++;
      if (mgmt_address == 6'd2) start_cyc = cyc;
    end
    if (done) begin
      e[0] = '{a: 6'd0, d: 32'd0};
      e[1] = '{a: 6'd7, d: model_applied ? FracNative : FracUnder};
      e[2] = '{a: 6'd2, d: 32'd0};
      chk_eq("done_applied", applied_sel, !model_applied);
      chk_eq("done_busy_low", busy, 0);
      chk_eq("seq_len", wq.size(), 3);
      if (wq.size() == 3) begin
        for (int j = 0; j < 3; j++) begin
          chk_eq($sformatf("seq%0d_addr", j), wq[j].a, e[j].a);
          chk_eq($sformatf("seq%0d_data", j), wq[j].d, e[j].d);
        end
      end
      wq.delete();
      model_applied = !model_applied;
      done_cnt++;
      done_cyc = cyc;
    end else begin
      chk_eq("applied_stable", applied_sel, model_applied);
    end
`ifdef PLL_LOCK_WAIT_EN
    if (lock_err) begin
      lock_err_cnt++;
      chk_eq("lock_err_with_done", done, 1);
    end
`else
    chk_eq("lock_err_tied", lock_err, 0);
`endif
    prev_valid = 1'b1;
    prev_write = mgmt_write;
    prev_wait  = mgmt_waitrequest;
    prev_acc   = acc;
    prev_addr  = mgmt_address;
    prev_data  = mgmt_writedata;
  endtask

  task automatic drive_wait();
    case (wmode)
      0: mgmt_waitrequest = 1'b0;
      1: begin
        if (!mgmt_write) stall_cnt = 0;
        if (mgmt_write && (stall_addr < 0 || int'(mgmt_address) == stall_addr)
            && stall_cnt < stall_n) begin
          mgmt_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          mgmt_waitrequest = 1'b0;
        end
      end
      2: mgmt_waitrequest = 1'($urandom_range(0, 1));
      default: mgmt_waitrequest = mgmt_write && mgmt_address == 6'd7;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    drive_wait();
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    chk_eq(name, int'(done_cnt != d0), 1);
  endtask

  task automatic ticks_to_write(input string name, input int exp);
    int k;
    k = 0;
    while (!mgmt_write && k < 20) begin
      tick();
      k++;
    end
    chk_eq(name, k, exp);
    chk_eq({name, "_addr"}, mgmt_address, 0);
  endtask

  vec_t vec[9];

  initial begin
    int hold_eff, d0, w0, a7, acc0, e0, n;

    vec[0] = '{1'b0, 100, 0, 1'b0, 0, 0};  // idle at native
    vec[1] = '{1'b1, 40,  0, 1'b1, 1, 3};  // switch to underclock
    vec[2] = '{1'b0, 2,   0, 1'b1, 0, 0};  // 2-cycle glitch
    vec[3] = '{1'b1, 40,  0, 1'b1, 0, 0};  // glitch ignored
    vec[4] = '{1'b0, 60,  5, 1'b0, 1, 3};  // back to native, every write stalled
    vec[5] = '{1'b1, 4,   0, 1'b0, 0, 0};  // pulse one short of acceptance
    vec[6] = '{1'b0, 30,  0, 1'b0, 0, 0};
    vec[7] = '{1'b1, 5,   0, 1'b0, 0, 0};  // shortest accepted pulse, starts a sequence
    vec[8] = '{1'b0, 80,  0, 1'b0, 2, 6};  // in-flight sequence finishes, then reverts

    checks = 0; errors = 0; cyc = 0;
    done_cnt = 0; wr_total = 0; acc7_cnt = 0; lock_err_cnt = 0;
    start_cyc = 0; done_cyc = 0;
    wmode = 0; stall_n = 0; stall_addr = -1; stall_cnt = 0;
    mon_clear();
    reset = 1'b1; sel = 1'b0; locked = 1'b1; mgmt_waitrequest = 1'b0;

    repeat (3) tick();
    chk_eq("rst_write", mgmt_write, 0);
    chk_eq("rst_addr", mgmt_address, 0);
    chk_eq("rst_data", mgmt_writedata, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_applied", applied_sel, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_lock_err", lock_err, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      sel        = vec[i].sel;
      wmode      = (vec[i].stall > 0) ? 1 : 0;
      stall_n    = vec[i].stall;
      stall_addr = -1;
      drive_wait();
      d0 = done_cnt;
      w0 = wr_total;
      hold_eff = (vec[i].hold >= 20) ? vec[i].hold + Extra : vec[i].hold;
      for (int c = 0; c < hold_eff; c++) tick();
      chk_eq($sformatf("vec%0d_applied", i), applied_sel, vec[i].exp_applied);
      chk_eq($sformatf("vec%0d_done", i), done_cnt - d0, vec[i].exp_done);
      chk_eq($sformatf("vec%0d_writes", i), wr_total - w0, vec[i].exp_writes);
    end

    // Select edge to first write: 2 sync + Stable debounce + 1 state cycles.
    wmode = 0; drive_wait();
    sel = 1'b1;
    ticks_to_write("sel_latency", Stable + 3);
    wait_done("latency_seq_done", 60 + Extra);
    chk_eq("latency_seq_applied", applied_sel, 1);

    // Frac write stalled 5 cycles: held 6 cycles, accepted once, native fraction.
    wmode = 1; stall_n = 5; stall_addr = 7; drive_wait();
    sel = 1'b0;
    d0 = done_cnt; acc0 = acc7_cnt; a7 = 0; n = 0;
    while (done_cnt == d0 && n < 120 + Extra) begin
      tick();
      n++;
      if (mgmt_write && mgmt_address == 6'd7) a7++;
    end
    chk_eq("stall_done", int'(done_cnt != d0), 1);
    chk_eq("stall_frac_cycles", a7, 6);
    chk_eq("stall_frac_accepts", acc7_cnt - acc0, 1);
    chk_eq("stall_applied", applied_sel, 0);

    // Reset while the frac write is stuck.
    wmode = 3; sel = 1'b1; drive_wait();
    n = 0;
    while (!(mgmt_write && mgmt_address == 6'd7) && n < 60) begin
      tick();
      n++;
    end
    chk_eq("reach_frac_write", int'(mgmt_write && mgmt_address == 6'd7), 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_eq("midrst_write", mgmt_write, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_applied", applied_sel, 0);
    reset = 1'b0; wmode = 0; drive_wait();
    ticks_to_write("restart_latency", Stable + 3);
    wait_done("restart_done", 60 + Extra);
    chk_eq("restart_applied", applied_sel, 1);

`ifdef PLL_LOCK_WAIT_EN
    // Lock never drops: silent unlock timeout, then immediate relock.
    locked = 1'b1; sel = 1'b0;
    e0 = lock_err_cnt;
    wait_done("unlock_to_done", 200);
    chk_eq("unlock_to_latency", done_cyc - start_cyc, LT + 3);
    chk_eq("unlock_to_no_err", lock_err_cnt - e0, 0);
    chk_eq("unlock_to_applied", applied_sel, 0);
    // Lock lost for good: lock_err once after the lock-wait timeout.
    locked = 1'b0;
    repeat (5) tick();
    sel = 1'b1;
    wait_done("lock_to_done", 200);
    chk_eq("lock_to_latency", done_cyc - start_cyc, LT + 3);
    chk_eq("lock_to_err_count", lock_err_cnt - e0, 1);
    chk_eq("lock_to_applied", applied_sel, 1);
    repeat (10) tick();
    chk_eq("lock_to_err_once", lock_err_cnt - e0, 1);
    locked = 1'b1;
    repeat (5) tick();
`endif

    // Random select activity with random waitrequest.
    e0 = lock_err_cnt;
    wmode = 2;
    for (int r = 0; r < 40; r++) begin
      sel = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 40);
      for (int c = 0; c < n; c++) tick();
    end
    wmode = 0; drive_wait();
    for (int c = 0; c < 200 + 2 * Extra; c++) tick();
    chk_eq("rand_final_applied", applied_sel, sel);
    chk_eq("rand_final_busy", busy, 0);
    chk_eq("rand_lock_err", lock_err_cnt - e0, 0);
    chk_eq("rand_queue_empty", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
